digit_stream_unit: RTL

Parametrised successor of the lab's digit-select module. It accepts a number (e.g. a student ID) as a serial stream of DW-bit digits, one digit per valid cycle. When a full frame arrives it snapshots the frame. It then serves addressed digit reads, add-with-accumulator, accumulator load and accumulator increment, all selected by the S/I mode pins. The accumulator M is a real internal register, so benches no longer poke DUT internals; all stimulus goes through ports.

---
 rtl/digit_stream_unit_if.sv | 34 +++
 rtl/digit_stream_unit.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/digit_stream_unit_if.sv
// digit_stream_unit_if: groups the serial digit input, the operation controls
// and the registered results of digit_stream_unit.
//   master: drives Din_valid, Din, A, S, I; observes B, Err, Frame_done,
//           Frame_valid, Busy, Bcd_err
//   slave : the digit_stream_unit side (opposite directions)
interface digit_stream_unit_if #(
    parameter int unsigned DIGITS = 8,
    parameter int unsigned DW     = 4,
    parameter int unsigned AW     = 5
);
    localparam int unsigned OUT_W = 2 * DW;

    logic              Din_valid;
    logic [DW-1:0]     Din;
    logic [AW-1:0]     A;
    logic              S;
    logic              I;
    logic [OUT_W-1:0]  B;
    logic              Err;
    logic              Frame_done;
    logic              Frame_valid;
    logic              Busy;
    logic              Bcd_err;

    modport master (
        output Din_valid, Din, A, S, I,
        input  B, Err, Frame_done, Frame_valid, Busy, Bcd_err
    );

    modport slave (
        input  Din_valid, Din, A, S, I,
        output B, Err, Frame_done, Frame_valid, Busy, Bcd_err
    );
endinterface

// File: rtl/digit_stream_unit.sv
// digit_stream_unit: collects a frame of DIGITS serial DW-bit digits (MSD
// first), snapshots it, and serves addressed digit read / add / accumulator
// load / accumulator increment selected by {S,I}. Results are registered
// (latency 1).
// Ports:
//   Clk  - clock, rising edge
//   Rst  - synchronous reset, active-high
//   bus  - digit_stream_unit_if.slave:
//          Din_valid, Din   serial digit input
//          A, S, I          digit address and mode select
//          B, Err           registered result / out-of-range flag
//          Frame_done       one-cycle pulse after a frame is captured
//          Frame_valid      sticky, a frame has been captured since reset
//          Busy             partial frame in progress (combinational)
//          Bcd_err          sticky BCD violation flag
// Optional feature: define DSU_BCD_CHECK_EN to flag any accepted digit > 9
// on Bcd_err; otherwise Bcd_err is tied low.
module digit_stream_unit #(
    parameter int unsigned DIGITS = 8,
    parameter int unsigned DW     = 4,
    parameter int unsigned AW     = 5
) (
    input  logic              Clk,
    input  logic              Rst,
    digit_stream_unit_if.slave bus
);
    localparam int unsigned OUT_W = 2 * DW;
    localparam int unsigned XW    = DIGITS * DW;
    localparam int unsigned CW    = $clog2(DIGITS);

    logic [XW-1:0]    x_q, x_d;
    logic [XW-1:0]    xs_q, xs_d;
    logic [DW-1:0]    m_q, m_d;
    logic [CW-1:0]    dcnt_q, dcnt_d;
    logic [OUT_W-1:0] b_q, b_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic             fv_q, fv_d;

    logic [XW-1:0]    x_shift;
    logic             last_digit;
    logic             in_range;
    logic [DW-1:0]    d;
    logic [DW-1:0]    m_inc;

    // State registers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            x_q    <= '0;
            xs_q   <= '0;
            m_q    <= '0;
            dcnt_q <= '0;
            b_q    <= '0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
            fv_q   <= 1'b0;
        end else begin
            x_q    <= x_d;
            xs_q   <= xs_d;
            m_q    <= m_d;
            dcnt_q <= dcnt_d;
            b_q    <= b_d;
            err_q  <= err_d;
            done_q <= done_d;
            fv_q   <= fv_d;
        end
    end

    // Shift path and frame capture
    always_comb begin
        x_shift    = {x_q[XW-DW-1:0], bus.Din};
        last_digit = bus.Din_valid && (dcnt_q == CW'(DIGITS - 1));
        x_d        = x_q;
        xs_d       = xs_q;
        dcnt_d     = dcnt_q;
        done_d     = 1'b0;
        fv_d       = fv_q;
        if (bus.Din_valid) begin
            x_d = x_shift;
            if (last_digit) begin
                xs_d   = x_shift;
                dcnt_d = '0;
                done_d = 1'b1;
                fv_d   = 1'b1;
            end else begin
                dcnt_d = dcnt_q + CW'(1);
            end
        end
    end

    // Digit select from the snapshot; compare in 32 bits so no address aliases
    always_comb begin
        in_range = (32'(bus.A) < DIGITS);
        d        = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (32'(bus.A) == k) begin
                d = xs_q[k*DW +: DW];
            end
        end
    end

    // Operation decode
    always_comb begin
        m_inc = m_q + DW'(1);
        m_d   = m_q;
        b_d   = '0;
        err_d = !in_range;
        case ({bus.S, bus.I})
            2'b00: b_d = OUT_W'(d);
            2'b01: b_d = OUT_W'(d) + OUT_W'(m_q);
            2'b10: begin
                m_d = d;
                b_d = {d, m_q};
            end
            default: begin
                m_d = m_inc;
                b_d = OUT_W'(m_inc);
            end
        endcase
    end

`ifdef DSU_BCD_CHECK_EN
    logic bcd_q, bcd_d;

    // Sticky flag for any accepted digit above 9
    always_comb begin
        bcd_d = bcd_q;
        if (bus.Din_valid && (32'(bus.Din) > 32'd9)) begin
            bcd_d = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            bcd_q <= 1'b0;
        end else begin
            bcd_q <= bcd_d;
        end
    end

    assign bus.Bcd_err = bcd_q;
`else
    assign bus.Bcd_err = 1'b0;
`endif

    assign bus.B           = b_q;
    assign bus.Err         = err_q;
    assign bus.Frame_done  = done_q;
    assign bus.Frame_valid = fv_q;
    assign bus.Busy        = (dcnt_q != '0);
endmodule
